ay_note_period_interp: RTL
==========================

Name: ay_note_period_interp

Overview:
- Multi-channel MIDI-note-to-AY tone-period converter with pitch-bend support.
- Accepts requests of {channel, note, signed bend}. Each request is converted to a 12-bit tone period by table lookup plus linear interpolation between adjacent semitones.
- The result is written into a per-channel period register that drives the YM2149 tone registers.
- Sits between the MIDI voice allocator and the AY register writer. Replaces the plain combinational note lookup.

Parameters:
- CHANNELS, 3, number of tone channels (1..8).
- PERIOD_W, 12, period width; must be ≥12 (table max 3977).
- FRAC_W, 5, bend fraction bits; 1 semitone = 2^FRAC_W steps.
- BEND_W, 8, signed bend width; default covers ±4 semitones.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- in_chan  in  3  target channel index.
- in_note  in  7  MIDI note 0..127.
- in_bend  in  BEND_W  signed bend in 1/2^FRAC_W semitone units.
- out_valid  out  1  one-cycle pulse when a channel register is updated.
- out_chan  out  3  channel just updated; valid with out_valid.
- period_out  out  CHANNELS*PERIOD_W  concatenated channel periods; channel k occupies bits [k*PERIOD_W +: PERIOD_W].

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - in_ready=1, out_valid=0, out_chan=0.
  - All period_out fields = 0.
  - FSM in IDLE.
- Any in-flight request is aborted by rst. in_ready=1 on the first cycle after rst deasserts.
- Handshake:
  - A request is accepted on a cycle where in_valid && in_ready.
  - in_ready=1 only in IDLE; inputs are registered at acceptance.
  - One request is outstanding at a time; no queue.
- Pitch computation:
  - pitch = {in_note, FRAC_W'b0} + sign-extended in_bend, evaluated signed at width 7+FRAC_W+1.
  - pitch is clamped to [0, 127<<FRAC_W].
  - n = pitch >> FRAC_W; f = pitch[FRAC_W-1:0].
- Table:
  - 128-entry synchronous ROM, one read port, 1-cycle read latency.
  - P[i] = round(1750000/(16·440·2^((i-69)/12))) for i≥21; P[i]=3977 for i<21.
  - Example values: P[59]=443, P[60]=418, P[69]=249, P[70]=235, P[127]=9.
- Interpolation:
  - n1 = min(n+1, 127).
  - period = P[n] − (((P[n]−P[n1])·f) >> FRAC_W), with truncation.
  - The product is unsigned, PERIOD_W+FRAC_W bits. The table is monotonic non-increasing, so the difference is never negative.
  - f=0 yields P[n] exactly.
- FSM states: IDLE → RD0 (address n) → RD1 (capture P[n], address n1) → CALC (capture P[n1], multiply/subtract) → WR → IDLE.
  - WR writes period_out[chan], pulses out_valid, and drives out_chan.
  - Latency: acceptance at cycle t gives out_valid at t+4. in_ready returns high at t+5. Throughput is 1 request per 5 cycles.
- in_chan ≥ CHANNELS: request is accepted and runs normally, but no register is written and out_valid stays 0 in WR.
- A channel not addressed keeps its value indefinitely.
- A repeated request to the same channel overwrites it; the last write wins.
- in_valid asserted while busy: ignored, because in_ready=0. The source must hold it until accepted.

Decomposition:
- Package ay_note_pkg holds:
  - AY_CLK_HZ=1750000.
  - NOTE_W=7.
  - the P[] table contents as a constant function or initial list.
  - MIN_NOTE_PERIOD=3977.
  - state encoding constants IDLE/RD0/RD1/CALC/WR.
- One sub-module: ay_note_rom, a synchronous 128×12 ROM (clk, addr[6:0], data[11:0]) initialised from the package. It is instantiated once.
- Interpolation and clamping stay in ay_note_period_interp.

Test Plan:
- Reset: assert rst 2 cycles → all period_out fields 0, in_ready=1, out_valid=0.
- chan0, note 69, bend 0 → out_valid at t+4, out_chan=0, field0=249, fields 1..2 unchanged.
- chan1, note 69, bend +16 → diff 14, 14·16>>5=7 → field1=242.
- Clamps:
  - note 127, bend +31 → field=9.
  - note 0, bend −128 → 3977.
  - note 10, bend 0 → 3977.
- Bend crossing a semitone: note 60, bend −32 → 443; bend −16 → n=59, f=16 → 443−12=431.
- Backpressure and abort:
  - Hold in_valid with two back-to-back requests → second accepted exactly at t+5.
  - Assert rst during CALC → no out_valid; registers cleared to 0.
  - in_chan=5 with CHANNELS=3 → no out_valid, no register changes.

Source files
------------

// File: rtl/ay_note_pkg.sv
// ay_note_pkg: shared constants, FSM encoding and AY tone-period table for MIDI notes.
package ay_note_pkg;
  localparam int AY_CLK_HZ = 1750000;
  localparam int NOTE_W = 7;
  localparam int MIN_NOTE_PERIOD = 3977;
  typedef enum logic [2:0] {IDLE, RD0, RD1, CALC, WR} state_t;
  // round(AY_CLK_HZ / (16 * f_note)); notes below 21 would overflow 12 bits, so they clamp
  localparam logic [11:0] NOTE_TABLE [21:127] = '{
    12'd3977, 12'd3754, 12'd3543, 12'd3344, 12'd3157, 12'd2980, 12'd2812, 12'd2655, 12'd2506, 12'd2365, 12'd2232, 12'd2107,
    12'd1989, 12'd1877, 12'd1772, 12'd1672, 12'd1578, 12'd1490, 12'd1406, 12'd1327, 12'd1253, 12'd1182, 12'd1116, 12'd1053,
    12'd994,  12'd939,  12'd886,  12'd836,  12'd789,  12'd745,  12'd703,  12'd664,  12'd626,  12'd591,  12'd558,  12'd527,
    12'd497,  12'd469,  12'd443,  12'd418,  12'd395,  12'd372,  12'd352,  12'd332,  12'd313,  12'd296,  12'd279,  12'd263,
    12'd249,  12'd235,  12'd221,  12'd209,  12'd197,  12'd186,  12'd176,  12'd166,  12'd157,  12'd148,  12'd140,  12'd132,
    12'd124,  12'd117,  12'd111,  12'd105,  12'd99,   12'd93,   12'd88,   12'd83,   12'd78,   12'd74,   12'd70,   12'd66,
    12'd62,   12'd59,   12'd55,   12'd52,   12'd49,   12'd47,   12'd44,   12'd41,   12'd39,   12'd37,   12'd35,   12'd33,
    12'd31,   12'd29,   12'd28,   12'd26,   12'd25,   12'd23,   12'd22,   12'd21,   12'd20,   12'd18,   12'd17,   12'd16,
    12'd16,   12'd15,   12'd14,   12'd13,   12'd12,   12'd12,   12'd11,   12'd10,   12'd10,   12'd9,    12'd9
  };
  function automatic logic [11:0] note_period(input logic [6:0] i);
    return (i < 7'd21) ? 12'(MIN_NOTE_PERIOD) : NOTE_TABLE[i];
  endfunction
endpackage

// File: rtl/ay_note_rom.sv
// ay_note_rom: 128x12 synchronous ROM of AY tone periods, one read port, 1-cycle latency.
module ay_note_rom
  import ay_note_pkg::*;
(
  input  logic        clk,
  input  logic [6:0]  addr,
  output logic [11:0] data
);
  always_ff @(posedge clk)
    data <= note_period(addr);
endmodule

// File: rtl/ay_note_period_interp.sv
// ay_note_period_interp: MIDI note + bend to per-channel AY tone period via table lookup and interpolation.
module ay_note_period_interp
  import ay_note_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int PERIOD_W = 12,
  parameter int FRAC_W   = 5,
  parameter int BEND_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_chan,
  input  logic [NOTE_W-1:0]            in_note,
  input  logic signed [BEND_W-1:0]     in_bend,
  output logic                         out_valid,
  output logic [2:0]                   out_chan,
  output logic [CHANNELS*PERIOD_W-1:0] period_out
);
  localparam int PW = NOTE_W + FRAC_W + 1;
  localparam int MW = PERIOD_W + FRAC_W;
  localparam logic signed [PW-1:0] PITCH_MAX = PW'((2**NOTE_W - 1) * 2**FRAC_W);
  state_t state, state_n;
  logic signed [PW-1:0] pitch;
  logic [PW-2:0] pitch_u;
  logic [2:0] chan_q;
  logic [NOTE_W-1:0] n_q, addr;
  logic [FRAC_W-1:0] f_q;
  logic [11:0] rom_data;
  logic [PERIOD_W-1:0] p0_q, p1, result;
  logic [MW-1:0] prod;
  logic [PERIOD_W-1:0] per_q [CHANNELS];
  logic chan_ok;
  assign pitch = $signed({1'b0, in_note, {FRAC_W{1'b0}}}) + PW'(in_bend);
  assign pitch_u = pitch[PW-1] ? '0 : (pitch > PITCH_MAX ? PITCH_MAX[PW-2:0] : pitch[PW-2:0]);
  assign in_ready = state == IDLE;
  assign chan_ok = 32'(chan_q) < CHANNELS;
  // RD0 fetches the base semitone; later states fetch its upper neighbour
  assign addr = state == RD0 ? n_q : (n_q == 7'd127 ? n_q : n_q + 7'd1);
  assign p1 = PERIOD_W'(rom_data);
  assign prod = MW'(p0_q - p1) * MW'(f_q);
  assign result = p0_q - PERIOD_W'(prod >> FRAC_W);
  ay_note_rom u_rom (
    .clk  (clk),
    .addr (addr),
    .data (rom_data)
  );
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (in_valid ? RD0 : IDLE) :
              state == RD0  ? RD1 :
              state == RD1  ? CALC :
              state == CALC ? WR : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_chan <= '0;
      for (int k = 0; k < CHANNELS; k++) per_q[k] <= '0;
    end else begin
      state <= state_n;
      out_valid <= state == CALC && chan_ok;
      if (state == CALC && chan_ok) begin
        out_chan <= chan_q;
        for (int k = 0; k < CHANNELS; k++)
          if (32'(chan_q) == k) per_q[k] <= result;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      chan_q <= in_chan;
      n_q <= pitch_u[PW-2:FRAC_W];
      f_q <= pitch_u[FRAC_W-1:0];
    end
    if (state == RD1) p0_q <= p1;
  end
  for (genvar k = 0; k < CHANNELS; k++) begin : g_out
    assign period_out[k*PERIOD_W +: PERIOD_W] = per_q[k];
  end
endmodule
